// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

    localparam int         ADDR_W      = 8;
    localparam int         DATA_W      = 16;
    localparam logic [3:0] HALT_OPCODE = 4'b1111;
    localparam logic [15:0] NOP_WORD   = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage : fetch_pkg

// File: rtl/instr_fetch.sv
// Instruction fetch unit in front of a registered-read instruction memory.
// One read is always in flight. During a stall the in-flight address is
// replayed, so no word is lost or duplicated. A redirect costs one bubble.
// A HALT word freezes the unit until reset.
module instr_fetch #(
    parameter int         ADDR_W      = fetch_pkg::ADDR_W,
    parameter int         DATA_W      = fetch_pkg::DATA_W,
    parameter logic [3:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] q,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted
);

    import fetch_pkg::*;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fpc;       // next fetch address
    logic [ADDR_W-1:0]   r_rpc;       // address of the in-flight read
    logic                r_rvalid;    // in-flight read is live
    logic [DATA_W-1:0]   r_ir;
    logic [ADDR_W-1:0]   r_ir_pc;
    logic                r_ir_valid;
    logic                r_halted;

    state_t              w_state_next;
    logic [ADDR_W-1:0]   w_fpc_next;
    logic [ADDR_W-1:0]   w_rpc_next;
    logic                w_rvalid_next;
    logic [DATA_W-1:0]   w_ir_next;
    logic [ADDR_W-1:0]   w_ir_pc_next;
    logic                w_ir_valid_next;
    logic                w_halted_next;
    logic                w_halt_hit;

    // A HALT is only consumed once it sits live in ir; in-flight or squashed
    // copies never reach this compare with ir_valid set.
    assign w_halt_hit = r_ir_valid && (r_ir[DATA_W-1 -: 4] == HALT_OPCODE);

    // Next-state, next-register and read-address selection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_next    = r_state;
        w_fpc_next      = r_fpc;
        w_rpc_next      = r_rpc;
        w_rvalid_next   = r_rvalid;
        w_ir_next       = r_ir;
        w_ir_pc_next    = r_ir_pc;
        w_ir_valid_next = r_ir_valid;
        w_halted_next   = r_halted;
        address         = r_fpc;

        if (r_state == RUN) begin
            if (redirect) begin
                // Fetch the target now; whatever was in flight is squashed.
                address         = redirect_addr;
                w_fpc_next      = redirect_addr + ADDR_W'(1);
                w_rpc_next      = redirect_addr;
                w_rvalid_next   = 1'b1;
                w_ir_next       = DATA_W'(NOP_WORD);
                w_ir_valid_next = 1'b0;
            end else if (stall) begin
                // Replay the in-flight address so q is still mem[rpc] when
                // the stall ends; all registers hold.
                address = r_rpc;
            end else if (w_halt_hit) begin
                w_state_next    = HALT;
                w_halted_next   = 1'b1;
                w_ir_valid_next = 1'b0;
            end else begin
                w_fpc_next      = r_fpc + ADDR_W'(1);
                w_rpc_next      = r_fpc;
                w_rvalid_next   = 1'b1;
                w_ir_next       = q;
                w_ir_pc_next    = r_rpc;
                w_ir_valid_next = r_rvalid;
            end
        end
    end

    // State and pipeline registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RUN;
            r_fpc      <= '0;
            r_rpc      <= '0;
            r_rvalid   <= 1'b0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state    <= w_state_next;
            r_fpc      <= w_fpc_next;
            r_rpc      <= w_rpc_next;
            r_rvalid   <= w_rvalid_next;
            r_ir       <= w_ir_next;
            r_ir_pc    <= w_ir_pc_next;
            r_ir_valid <= w_ir_valid_next;
            r_halted   <= w_halted_next;
        end
    end

    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;
    assign halted   = r_halted;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a registered-read ROM.
module tb_instr_fetch;

    logic        clock;
    logic        reset_n;
    logic [7:0]  address;
    logic [15:0] q;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [7:0]  raddr;
        logic [15:0] exp_ir;
        logic [7:0]  exp_pc;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    instr_fetch dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .q             (q),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .halted        (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read instruction ROM.
    always @(posedge clock) q <= mem[address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_ir, input logic [7:0] e_pc,
                             input logic e_valid, input logic e_halted);
        check({tag, ".ir"},       32'(ir),       32'(e_ir));
        check({tag, ".ir_pc"},    32'(ir_pc),    32'(e_pc));
        check({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_valid));
        check({tag, ".halted"},   32'(halted),   32'(e_halted));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ir"},       32'(ir),       32'h0);
        check({tag, ".ir_pc"},    32'(ir_pc),    32'h0);
        check({tag, ".ir_valid"}, 32'(ir_valid), 32'h0);
        check({tag, ".halted"},   32'(halted),   32'h0);
        check({tag, ".address"},  32'(address),  32'h0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        reset_n = 1'b0;

        // Vectors: {stall, redirect, redirect_addr, ir, ir_pc, ir_valid} after each edge.
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0100, 8'h00, 1'b0});  // first edge: address 0 issued
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0100, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0101, 8'h01, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0102, 8'h02, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0103, 8'h03, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0104, 8'h04, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0104, 8'h04, 1'b1});  // stall x3
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0104, 8'h04, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 16'h0104, 8'h04, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0105, 8'h05, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0106, 8'h06, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0107, 8'h07, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0108, 8'h08, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0109, 8'h09, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h010A, 8'h0A, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 8'h05, 16'h0000, 8'h0A, 1'b0});  // redirect to 5: bubble
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0105, 8'h05, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0106, 8'h06, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0107, 8'h07, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'h20, 16'h0000, 8'h07, 1'b0});  // stall+redirect: redirect wins
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0120, 8'h20, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0121, 8'h21, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 8'hFE, 16'h0000, 8'h21, 1'b0});  // redirect near top: wrap
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h01FE, 8'hFE, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h01FF, 8'hFF, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0100, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 16'h0101, 8'h01, 1'b1});

        // Reset state, held across a couple of edges.
        #2;
        check_reset_outputs("reset");
        step();
        step();
        check_reset_outputs("reset_held");
        reset_n = 1'b1;

        // Table-driven run: streaming, stall, redirect, stall+redirect, wrap.
        foreach (vecs[i]) begin
            stall         = vecs[i].stall;
            redirect      = vecs[i].redirect;
            redirect_addr = vecs[i].raddr;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_pc,
                      vecs[i].exp_valid, 1'b0);
        end
        stall = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;

        // Mid-operation reset while ir_pc=7.
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            step();
            if (ir_valid && ir_pc == 8'h07) found = 1'b1;
        end
        check("midreset.reach_pc7", 32'(found), 32'h1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset.async");
        step();
        check_reset_outputs("midreset.held");
        reset_n = 1'b1;
        step();
        check_out("midreset.e1", 16'h0100, 8'h00, 1'b0, 1'b0);
        step();
        check_out("midreset.e2", 16'h0100, 8'h00, 1'b1, 1'b0);
        step();
        check_out("midreset.e3", 16'h0101, 8'h01, 1'b1, 1'b0);

        // HALT word at address 3.
        mem[3] = 16'hF000;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        check_out("halt.pc3", 16'hF000, 8'h03, 1'b1, 1'b0);
        step();
        check("halt.halted",   32'(halted),   32'h1);
        check("halt.ir_valid", 32'(ir_valid), 32'h0);
        check("halt.address",  32'(address),  32'h05);
        for (int k = 0; k < 4; k++) begin
            stall         = k[0];
            redirect      = k[1] | k[0];
            redirect_addr = 8'h40;
            #1;
            check($sformatf("halt.frozen_addr%0d", k), 32'(address), 32'h05);
            step();
            check($sformatf("halt.frozen_halted%0d", k), 32'(halted),   32'h1);
            check($sformatf("halt.frozen_valid%0d", k),  32'(ir_valid), 32'h0);
            check($sformatf("halt.frozen_pc%0d", k),     32'(ir_pc),    32'h03);
        end
        stall = 1'b0; redirect = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width.
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter HALT_OPCODE, default 4'b1111, value of word[15:12] that ends execution.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  output  ADDR_W  read address to the instruction memory; the memory returns q one clock later (registered read).
REQ-007 q  input  DATA_W  instruction word for the address presented in the previous cycle.
REQ-008 stall  input  1  core cannot accept a new instruction; ir holds.
REQ-009 redirect  input  1  jump/branch taken; refetch from redirect_addr.
REQ-010 redirect_addr  input  ADDR_W  jump/branch target.
REQ-011 ir  output  DATA_W  instruction presented to the core.
REQ-012 ir_pc  output  ADDR_W  address of the word in ir.
REQ-013 ir_valid  output  1  ir holds a live instruction.
REQ-014 halted  output  1  HALT word consumed; fetch stopped.

Function
REQ-015 Internal registers: fpc (next fetch address), rpc (address of the in-flight read), rvalid (in-flight read live), state in {RUN, HALT}.
REQ-016 address is combinational, with this priority: RUN and redirect -> redirect_addr; RUN and stall -> rpc (replay); RUN otherwise -> fpc; HALT -> fpc (frozen).
REQ-017 RUN, no stall, no redirect, per edge: fpc <= fpc+1; rpc <= fpc; rvalid <= 1; ir <= q; ir_pc <= rpc; ir_valid <= rvalid.
REQ-018 RUN with stall and no redirect: fpc, rpc, rvalid, ir, ir_pc and ir_valid all hold.
REQ-019 Because of the replay address in REQ-016, the first edge after stall deasserts captures q = mem[rpc]; no word is lost or duplicated for any stall length.
REQ-020 redirect has priority over stall and applies in RUN only.
REQ-021 On a redirect edge: fpc <= redirect_addr+1; rpc <= redirect_addr; rvalid <= 1; ir <= 16'h0000 (NOP); ir_valid <= 0.
REQ-022 Redirect penalty is exactly one bubble: the target word appears in ir with ir_valid=1 on the second edge after redirect is sampled.
REQ-023 A HALT word is consumed on an edge in RUN where ir_valid=1, ir[15:12]=HALT_OPCODE, stall=0 and redirect=0; on that edge: state <= HALT, halted <= 1, ir_valid <= 0.
REQ-024 A HALT word still in flight or squashed by a redirect does not halt.
REQ-025 HALT state: all registers frozen, and stall and redirect are ignored; only reset exits.
REQ-026 fpc and rpc wrap modulo 2^ADDR_W (255+1 -> 0); wrap raises no flag.
REQ-027 No ir_valid=1 cycle ever carries a word fetched before the most recent redirect.

Reset
REQ-028 While reset_n=0: fpc=0, rpc=0, rvalid=0, ir=0, ir_pc=0, ir_valid=0, halted=0, state=RUN, address=0.
REQ-029 Reset asserted mid-operation clears all state immediately; the fetch then restarts from address 0.
REQ-030 After reset_n rises, the first edge issues address 0; the second edge presents mem[0] with ir_valid=1 and ir_pc=0.

Structure
REQ-031 Package fetch_pkg holds ADDR_W, DATA_W, HALT_OPCODE, NOP_WORD (16'h0000) and the state enum {RUN, HALT}.
REQ-032 Single flat module; no sub-module is required.

Verification
REQ-033 The bench models the instruction memory as a registered-read ROM with mem[i] = 16'h0100+i, except where a scenario overrides a word.
REQ-034 Reset release, no stall -> ir_pc sequence 0,1,2,3 on consecutive cycles; ir = 16'h0100, 16'h0101, ...; ir_valid=1 from the second edge.
REQ-035 stall high for 3 cycles while ir_pc=4 -> ir holds 16'h0104 for 4 cycles, then 16'h0105, 16'h0106 with no gap or repeat.
REQ-036 redirect=1, redirect_addr=8'h05 while ir_pc=10 -> one cycle with ir_valid=0, then ir_pc=5, 6, 7; words 11 and 12 never appear valid.
REQ-037 mem[3]=16'hF000 -> ir_pc 0..3 presented; halted=1 and ir_valid=0 from the next cycle; address frozen at 5; stall/redirect toggling has no effect.
REQ-038 Redirect to 8'hFE -> ir_pc 254, 255, 0, 1.
REQ-039 reset_n pulsed low while ir_pc=7 -> all outputs zero during reset; REQ-030 sequence follows.
REQ-040 stall and redirect asserted in the same cycle -> redirect wins per REQ-021.
